enc4x2: RTL
===========

ENC4X2 -- requirements
Module: enc4x2

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 x0..x3  input  1 each  event lines; x3 highest index.
REQ-005 y1,y0  output  1 each  registered 2-bit code of granted event (y1 = MSB).
REQ-006 vld  output  1  code valid.
REQ-007 rdy  input  1  consumer ready; handshake completes on a cycle with vld=1 and rdy=1.
REQ-008 ovf  output  1  sticky overflow flag.

Function
REQ-009 Pending register p[3:0]: x_i=1 sampled at an edge sets p[i] at that edge; p[i] is cleared only by handshake of code i or by reset.
REQ-010 FSM states: IDLE (vld=0) and HOLD (vld=1).
REQ-011 IDLE: p!=0 at an edge -> select index, load y1,y0, go to HOLD; p==0 -> stay in IDLE, y1,y0 hold their value.
REQ-012 Latency: x_i first high in cycle 0 with p empty -> p[i] set after edge 0 -> vld=1 and code=i after edge 1.
REQ-013 HOLD: y1,y0 and vld stable while rdy=0; no reselection even if a higher-priority bit becomes pending.
REQ-014 HOLD with rdy=1 at edge: clear p[code]; if the remaining p (the value before this edge's x sampling, minus the granted bit) is nonzero, load the next selection and stay in HOLD (back-to-back, one code per cycle); otherwise go to IDLE, vld=0.
REQ-015 Simultaneous events: x_i=1 at the same edge p[i] is cleared by handshake -> p[i] stays set (new event), ovf not set.
REQ-016 Overflow: x_i=1 at an edge while p[i]=1 and not being cleared -> ovf=1 from that edge until reset; the event is merged (no count).
REQ-017 Selection (default): fixed priority, highest pending index wins (3 > 2 > 1 > 0).
REQ-018 All outputs registered; no combinational path from x* or rdy to any output.

Reset
REQ-019 rst=1 at an edge: p=0000, state=IDLE, vld=0, y1=0, y0=0, ovf=0, RR pointer=3.
REQ-020 Reset mid-HOLD discards the pending code and all pending events; x* sampled at a reset edge is ignored.
REQ-021 First edge with rst=0 behaves as IDLE with empty p.

Configuration
REQ-022 Macro ENC4X2_RR_EN defined: round-robin selection; pointer holds last granted index, search starts at pointer+1 mod 4 wrapping 3->0; pointer updates on each load of y1,y0.
REQ-023 ENC4X2_RR_EN undefined: fixed priority per REQ-017; pointer logic absent; interface identical.

Verification
REQ-024 Reset, then x2=1 for cycle 0, rdy=1 -> vld=1, code=10 after edge 1; vld=0 after edge 2; ovf=0.
REQ-025 x0..x3 all high for one cycle, rdy=1, fixed priority -> codes 11,10,01,00 on four consecutive cycles, then vld=0.
REQ-026 Same stimulus with ENC4X2_RR_EN, pointer=3 after reset -> codes 00,01,10,11 on consecutive cycles.
REQ-027 x1 pulse, rdy=0 for 5 cycles, x3 pulse during hold -> code stays 01 until rdy=1; then 11 next cycle (fixed priority).
REQ-028 x1 held high 3 cycles with rdy=0 -> ovf=1 after second edge; x1 high exactly on the handshake edge of code 01 -> code 01 re-issued, ovf unchanged.
REQ-029 rst asserted during HOLD with p=1010 -> vld=0, code=00, p empty after that edge; no stale code delivered after release.

Source files
------------

// File: rtl/enc4x2.sv
`default_nettype none
// ============================================================================
// Module   : enc4x2
// Purpose  : 4-to-2 event encoder with sticky pending bits, a valid/ready
//            output handshake and a sticky overflow flag. Each event line
//            x0..x3 sets a pending bit. The encoder grants one pending index
//            at a time and presents its 2-bit code on {y1,y0} until the
//            consumer accepts it.
// Ports    : clk       - single clock, rising edge
//            rst       - synchronous, active-high reset
//            x0..x3    - event lines (x3 = highest index)
//            rdy       - consumer ready; handshake = vld & rdy at an edge
//            y1,y0     - registered code of the granted event (y1 = MSB)
//            vld       - code valid (high while in HOLD)
//            ovf       - sticky overflow: an event arrived on an index that
//                        was still pending and was not being cleared
// Config   : ENC4X2_RR_EN - when defined, selection is round-robin and
//            starts after the last granted index. When undefined, the
//            highest pending index wins (fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module enc4x2 (
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic rdy,
    output logic y1,
    output logic y0,
    output logic vld,
    output logic ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_p;
    logic [1:0]  r_code;
    logic        r_ovf;

    logic [3:0]  w_x;
    logic        w_hs;
    logic [3:0]  w_clr;
    logic [3:0]  w_cand;
    logic [3:0]  w_p_nxt;
    logic        w_ovf_set;
    logic [1:0]  w_sel;
    logic        w_load;

    assign w_x  = {x3, x2, x1, x0};
    assign w_hs = (r_state == ST_HOLD) && rdy;

    // The bit of the code being accepted at this edge. It is zero outside a
    // handshake, so w_cand is simply r_p in IDLE.
    assign w_clr  = w_hs ? (4'b0001 << r_code) : 4'b0000;
    assign w_cand = r_p & ~w_clr;

    // A new event on the same index as the accepted code re-arms that bit.
    // It is a fresh event, not an overflow.
    assign w_p_nxt   = w_cand | w_x;
    assign w_ovf_set = |(w_x & w_cand);

`ifdef ENC4X2_RR_EN
    logic [1:0] r_ptr;

    // Search order is ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). The loop runs
    // backwards so that the last match it finds is the first one in that order.
    always_comb begin
        w_sel = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (w_cand[r_ptr + 2'(k)]) begin
                w_sel = r_ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd3;
        end else if (w_load) begin
            r_ptr <= w_sel;
        end
    end
`else
    // Ascending scan. The last match wins, so the highest pending index is
    // selected.
    always_comb begin
        w_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_cand[i]) begin
                w_sel = 2'(i);
            end
        end
    end
`endif

    // Next-state logic and load of the code register.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The code stays frozen until it is accepted. A higher-priority
                // arrival does not cause a new selection.
                if (rdy) begin
                    if (|w_cand) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_p     <= 4'b0000;
            r_code  <= 2'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            if (w_load) begin
                r_code <= w_sel;
            end
        end
    end

    assign y1  = r_code[1];
    assign y0  = r_code[0];
    assign vld = (r_state == ST_HOLD);
    assign ovf = r_ovf;

endmodule
`default_nettype wire
